vga_pattern_gen: RTL and testbench

- Parametrised successor to the fixed 640x480 colour-bar test block.
- Generates VGA sync timing for any resolution set by parameters.
- Produces one of four run-time-selectable test patterns at configurable colour depth: colour bars, checkerboard, gradient, scrolling bars.
- Sits between the pixel-clock domain and the top-level pin mapper, which packs hsync/vsync/RGB onto uo_out.

---
 rtl/vga_pattern_gen.sv | 194 +++++++++++++++++++
 tb/tb_vga_pattern_gen.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_pattern_gen.sv
// rtl/vga_pattern_gen.sv - parametrised VGA sync generator with four selectable test patterns
//
// Ports:
//   clk, rst_n          pixel-domain clock, asynchronous active-low reset
//   ena                 pixel tick; all counters advance only when high
//   mode[1:0]           pattern select (0 bars, 1 checker, 2 gradient, 3 scrolling bars),
//                       taken into use only at the frame wrap
//   hsync, vsync        sync pulses at SYNC_POL inside their windows
//   display_on          visible-region flag
//   hpos, vpos          registered pixel column / line
//   r, g, b             CBIT-wide colour channels, zero outside the visible region
//   frame_start         one-clock pulse when hpos/vpos first show 0,0 after a frame wrap
module vga_pattern_gen #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter int SYNC_POL = 0,
    parameter int CBIT     = 2,
    parameter int CHK_LOG2 = 5
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            ena,
    input  logic [1:0]      mode,
    output logic            hsync,
    output logic            vsync,
    output logic            display_on,
    output logic [9:0]      hpos,
    output logic [9:0]      vpos,
    output logic [CBIT-1:0] r,
    output logic [CBIT-1:0] g,
    output logic [CBIT-1:0] b,
    output logic            frame_start
);

    localparam int         H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int         V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
    localparam logic [9:0] BAR_LAST = 10'(H_ACTIVE / 8 - 1);
    localparam logic [9:0] HA       = 10'(H_ACTIVE);
    localparam logic [9:0] VA       = 10'(V_ACTIVE);
    localparam logic [9:0] HS_BEG   = 10'(H_ACTIVE + H_FP);
    localparam logic [9:0] HS_END   = 10'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [9:0] VS_BEG   = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0] VS_END   = 10'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic       SYNC_ON  = (SYNC_POL != 0);

    // Timing / pattern state
    logic [9:0] hcnt_q, hcnt_d, vcnt_q, vcnt_d;
    logic [9:0] bar_px_q, bar_px_d;
    logic [2:0] bar_idx_q, bar_idx_d;
    logic [7:0] frame_cnt_q, frame_cnt_d;
    logic [1:0] mode_q, mode_d;
    logic       wrap_pend_q, wrap_pend_d;

    // Registered outputs
    logic            hsync_q, hsync_d, vsync_q, vsync_d, disp_q, disp_d;
    logic [9:0]      hpos_q, vpos_q;
    logic [CBIT-1:0] r_q, r_d, g_q, g_d, b_q, b_d;
    logic            fs_q;

    logic       h_end, v_end, frame_wrap;
    logic [2:0] start_idx;
    logic [2:0] bar_col;
    logic       chk;

    always_comb begin
        h_end       = (hcnt_q == H_LAST);
        v_end       = (vcnt_q == V_LAST);
        frame_wrap  = ena && h_end && v_end;

        hcnt_d      = hcnt_q;
        vcnt_d      = vcnt_q;
        bar_px_d    = bar_px_q;
        bar_idx_d   = bar_idx_q;
        frame_cnt_d = frame_cnt_q;
        mode_d      = mode_q;
        wrap_pend_d = frame_wrap;

        if (frame_wrap) begin
            frame_cnt_d = frame_cnt_q + 8'd1;
            mode_d      = mode;
        end

        // Bar start uses the post-wrap mode/frame so a new frame opens with its own offset.
        start_idx = (mode_d == 2'd3) ? frame_cnt_d[7:5] : 3'd0;

        if (ena) begin
            if (h_end) begin
                hcnt_d    = 10'd0;
                vcnt_d    = v_end ? 10'd0 : vcnt_q + 10'd1;
                bar_px_d  = 10'd0;
                bar_idx_d = start_idx;
            end else begin
                hcnt_d = hcnt_q + 10'd1;
                if (bar_px_q == BAR_LAST) begin
                    bar_px_d  = 10'd0;
                    bar_idx_d = bar_idx_q + 3'd1;
                end else begin
                    bar_px_d = bar_px_q + 10'd1;
                end
            end
        end
    end

    always_comb begin
        hsync_d = ((hcnt_q >= HS_BEG) && (hcnt_q < HS_END)) ? SYNC_ON : ~SYNC_ON;
        vsync_d = ((vcnt_q >= VS_BEG) && (vcnt_q < VS_END)) ? SYNC_ON : ~SYNC_ON;
        disp_d  = (hcnt_q < HA) && (vcnt_q < VA);

        bar_col = 3'd7 - bar_idx_q;
        chk     = hcnt_q[CHK_LOG2] ^ vcnt_q[CHK_LOG2];

        case (mode_q)
            2'd1: begin
                r_d = {CBIT{chk}};
                g_d = {CBIT{chk}};
                b_d = {CBIT{chk}};
            end
            2'd2: begin
                r_d = hcnt_q[9 -: CBIT];
                g_d = vcnt_q[9 -: CBIT];
                b_d = frame_cnt_q[7 -: CBIT];
            end
            default: begin
                r_d = {CBIT{bar_col[2]}};
                g_d = {CBIT{bar_col[1]}};
                b_d = {CBIT{bar_col[0]}};
            end
        endcase

        if (!disp_d) begin
            r_d = '0;
            g_d = '0;
            b_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hcnt_q      <= '0;
            vcnt_q      <= '0;
            bar_px_q    <= '0;
            bar_idx_q   <= '0;
            frame_cnt_q <= '0;
            mode_q      <= '0;
            wrap_pend_q <= 1'b0;
            hsync_q     <= ~SYNC_ON;
            vsync_q     <= ~SYNC_ON;
            disp_q      <= 1'b0;
            hpos_q      <= '0;
            vpos_q      <= '0;
            r_q         <= '0;
            g_q         <= '0;
            b_q         <= '0;
            fs_q        <= 1'b0;
        end else begin
            hcnt_q      <= hcnt_d;
            vcnt_q      <= vcnt_d;
            bar_px_q    <= bar_px_d;
            bar_idx_q   <= bar_idx_d;
            frame_cnt_q <= frame_cnt_d;
            mode_q      <= mode_d;
            wrap_pend_q <= wrap_pend_d;
            hsync_q     <= hsync_d;
            vsync_q     <= vsync_d;
            disp_q      <= disp_d;
            hpos_q      <= hcnt_q;
            vpos_q      <= vcnt_q;
            r_q         <= r_d;
            g_q         <= g_d;
            b_q         <= b_d;
            // Pulse aligns with the first clk where hpos/vpos show 0,0.
            fs_q        <= wrap_pend_q;
        end
    end

    assign hsync       = hsync_q;
    assign vsync       = vsync_q;
    assign display_on  = disp_q;
    assign hpos        = hpos_q;
    assign vpos        = vpos_q;
    assign r           = r_q;
    assign g           = g_q;
    assign b           = b_q;
    assign frame_start = fs_q;

endmodule

// File: tb/tb_vga_pattern_gen.sv
// tb/tb_vga_pattern_gen.sv - self-checking bench for vga_pattern_gen on a reduced raster
module tb_vga_pattern_gen;

    localparam int HA = 32, HF = 4, HS = 8, HB = 4;
    localparam int VA = 16, VF = 2, VS = 2, VB = 2;
    localparam int POL = 0, CB = 2, CK = 2;
    localparam int HT = HA + HF + HS + HB;
    localparam int VT = VA + VF + VS + VB;
    localparam int BW = HA / 8;
    localparam int FULL = (1 << CB) - 1;
    localparam int VW = 3 + 20 + 3 * CB + 1;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          ena = 1'b0;
    logic [1:0]    mode = 2'd0;
    logic          hsync, vsync, display_on, frame_start;
    logic [9:0]    hpos, vpos;
    logic [CB-1:0] r, g, b;

    vga_pattern_gen #(
        .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
        .SYNC_POL(POL), .CBIT(CB), .CHK_LOG2(CK)
    ) dut (
        .clk(clk), .rst_n(rst_n), .ena(ena), .mode(mode),
        .hsync(hsync), .vsync(vsync), .display_on(display_on),
        .hpos(hpos), .vpos(vpos), .r(r), .g(g), .b(b),
        .frame_start(frame_start)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    logic          on_lvl;
    logic [VW-1:0] exp_vec, rst_vec;
    wire  [VW-1:0] act_vec = {hsync, vsync, display_on, hpos, vpos, r, g, b, frame_start};

    // Reference model: raster position, frame number, active mode, pending frame pulse
    int m_h, m_v, m_fr, m_mode;
    bit m_pend;

    function automatic void exp_rgb(input int h, input int v, input int md, input int fr,
                                    output int er, output int eg, output int eb);
        int idx, c;
        er = 0; eg = 0; eb = 0;
        if (h < HA && v < VA) begin
            case (md)
                1: begin
                    er = (((h >> CK) ^ (v >> CK)) & 1) ? FULL : 0;
                    eg = er; eb = er;
                end
                2: begin
                    er = h >> (10 - CB);
                    eg = v >> (10 - CB);
                    eb = fr >> (8 - CB);
                end
                default: begin
                    idx = (h / BW + ((md == 3) ? fr / 32 : 0)) % 8;
                    c = 7 - idx;
                    er = ((c >> 2) & 1) ? FULL : 0;
                    eg = ((c >> 1) & 1) ? FULL : 0;
                    eb = (c & 1) ? FULL : 0;
                end
            endcase
        end
    endfunction

    task automatic model_reset();
        m_h = 0; m_v = 0; m_fr = 0; m_mode = 0; m_pend = 0;
        exp_vec = rst_vec;
    endtask

    // Drives one clock with the given ena, advances the model, returns #1 after the edge.
    task automatic tick(input logic en);
        int er, eg, eb;
        logic hs_e, vs_e, dp_e;
        ena = en;
        exp_rgb(m_h, m_v, m_mode, m_fr, er, eg, eb);
        hs_e = (m_h >= HA + HF && m_h < HA + HF + HS) ? on_lvl : ~on_lvl;
        vs_e = (m_v >= VA + VF && m_v < VA + VF + VS) ? on_lvl : ~on_lvl;
        dp_e = (m_h < HA && m_v < VA);
        exp_vec = {hs_e, vs_e, dp_e, 10'(m_h), 10'(m_v), CB'(er), CB'(eg), CB'(eb), m_pend};
        @(posedge clk);
        m_pend = 0;
        if (en) begin
            if (m_h == HT - 1) begin
                m_h = 0;
                if (m_v == VT - 1) begin
                    m_v = 0;
                    m_fr = (m_fr + 1) % 256;
                    m_mode = mode;
                    m_pend = 1;
                end else begin
                    m_v++;
                end
            end else begin
                m_h++;
            end
        end
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        ena = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        n_tests++;
        if (act_vec !== rst_vec) begin
            n_fail++;
            $display("FAIL reset_state: got %h expected %h", act_vec, rst_vec);
        end
        rst_n = 1'b1;
        model_reset();
    endtask

    task automatic test_sync_timing();
        int hs_cnt = 0, vs_cnt = 0, fs_cnt = 0;
        int px0 = -1, px1 = -1, px7 = -1;
        mode = 2'd0;
        for (int i = 0; i < HT * VT + 1; i++) begin
            tick(1'b1);
            n_tests++;
            if (act_vec !== exp_vec) begin
                n_fail++;
                if (n_fail < 30) $display("FAIL sync_frame cyc %0d: got %h expected %h", i, act_vec, exp_vec);
            end
            if (i < HT * VT) begin
                if (hsync == on_lvl) hs_cnt++;
                if (vsync == on_lvl) vs_cnt++;
            end
            if (frame_start) fs_cnt++;
            if (vpos == 10'd2 && hpos == 10'd0)      px0 = {r, g, b};
            if (vpos == 10'd2 && hpos == 10'(BW))    px1 = {r, g, b};
            if (vpos == 10'd2 && hpos == 10'(HA-1))  px7 = {r, g, b};
        end
        n_tests++;
        if (hs_cnt != HS * VT) begin
            n_fail++; $display("FAIL hsync_width: got %0d expected %0d", hs_cnt, HS * VT);
        end
        n_tests++;
        if (vs_cnt != VS * HT) begin
            n_fail++; $display("FAIL vsync_width: got %0d expected %0d", vs_cnt, VS * HT);
        end
        n_tests++;
        if (fs_cnt != 1) begin
            n_fail++; $display("FAIL frame_start_count: got %0d expected 1", fs_cnt);
        end
        n_tests++;
        if (px0 != 'h3F || px1 != 'h3C || px7 != 0) begin
            n_fail++; $display("FAIL bar_colours: got %h %h %h expected 3f 3c 0", px0, px1, px7);
        end
    endtask

    task automatic test_patterns();
        for (int f = 0; f < 4; f++) begin
            int chg = $urandom_range(HT * VT - 2, 1);
            for (int i = 0; i < HT * VT; i++) begin
                if (i == chg) mode = (f == 0) ? 2'd1 : (f == 1) ? 2'd2 : 2'($urandom);
                tick(1'b1);
                n_tests++;
                if (act_vec !== exp_vec) begin
                    n_fail++;
                    if (n_fail < 30) $display("FAIL pattern f%0d cyc %0d: got %h expected %h", f, i, act_vec, exp_vec);
                end
            end
        end
    endtask

    task automatic test_scroll();
        int guard = 0;
        int seen = -1;
        mode = 2'd0;
        while (!(m_pend) && guard < 2 * HT * VT) begin
            tick(1'b1); guard++;
        end
        guard = 0;
        while (!(m_h == 0 && m_v == 11) && guard < 2 * HT * VT) begin
            if (m_v == 10 && m_h == 0) mode = 2'd3;
            tick(1'b1); guard++;
        end
        tick(1'b1);
        seen = {r, g, b};
        n_tests++;
        if (seen != 'h3F || m_mode != 0) begin
            n_fail++; $display("FAIL mode_midframe: got %h expected 3f", seen);
        end
        guard = 0;
        while (!(m_fr == 32 && m_pend) && guard < 40 * HT * VT) begin
            tick(1'b1); guard++;
            n_tests++;
            if (act_vec !== exp_vec) begin
                n_fail++;
                if (n_fail < 30) $display("FAIL scroll cyc %0d: got %h expected %h", guard, act_vec, exp_vec);
            end
        end
        n_tests++;
        if (!(m_fr == 32 && m_pend)) begin
            n_fail++; $display("FAIL scroll_timeout: got frame %0d expected 32", m_fr);
        end
        tick(1'b1);
        n_tests++;
        if ({r, g, b} !== 6'h3C || hpos !== 10'd0 || vpos !== 10'd0 || frame_start !== 1'b1) begin
            n_fail++; $display("FAIL scroll_bar0: got rgb %h fs %b expected 3c 1", {r, g, b}, frame_start);
        end
    endtask

    task automatic test_ena();
        int run = 0, width = -1;
        bit armed = 0;
        for (int i = 0; i < HT * 4 * 3; i++) begin
            tick(i % 4 == 0);
            n_tests++;
            if (act_vec !== exp_vec) begin
                n_fail++;
                if (n_fail < 30) $display("FAIL ena_quarter cyc %0d: got %h expected %h", i, act_vec, exp_vec);
            end
            if (hsync != on_lvl) begin
                if (armed && run > 0 && width < 0) width = run;
                armed = 1; run = 0;
            end else if (armed) begin
                run++;
            end
        end
        n_tests++;
        if (width != HS * 4) begin
            n_fail++; $display("FAIL ena_hsync_width: got %0d expected %0d", width, HS * 4);
        end
        for (int i = 0; i < 600; i++) begin
            tick(1'($urandom));
            n_tests++;
            if (act_vec !== exp_vec) begin
                n_fail++;
                if (n_fail < 30) $display("FAIL ena_random cyc %0d: got %h expected %h", i, act_vec, exp_vec);
            end
        end
    endtask

    task automatic test_reset_mid();
        int guard = 0, cnt = -1;
        mode = 2'd3;
        while (m_v != 8 && guard < 2 * HT * VT) begin
            tick(1'b1); guard++;
        end
        #2 rst_n = 1'b0;
        #1;
        n_tests++;
        if (act_vec !== rst_vec) begin
            n_fail++; $display("FAIL reset_async: got %h expected %h", act_vec, rst_vec);
        end
        mode = 2'd0;
        ena = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        n_tests++;
        if (act_vec !== rst_vec) begin
            n_fail++; $display("FAIL reset_hold: got %h expected %h", act_vec, rst_vec);
        end
        rst_n = 1'b1;
        model_reset();
        for (int i = 1; i <= HT * VT + 5; i++) begin
            tick(1'b1);
            n_tests++;
            if (act_vec !== exp_vec) begin
                n_fail++;
                if (n_fail < 30) $display("FAIL post_reset cyc %0d: got %h expected %h", i, act_vec, exp_vec);
            end
            if (frame_start && cnt < 0) cnt = i;
        end
        n_tests++;
        if (cnt != HT * VT + 1) begin
            n_fail++; $display("FAIL first_frame_start: got %0d expected %0d", cnt, HT * VT + 1);
        end
    endtask

    initial begin
        on_lvl  = (POL != 0);
        rst_vec = {~on_lvl, ~on_lvl, 1'b0, 10'd0, 10'd0, {3 * CB{1'b0}}, 1'b0};
        model_reset();
        test_reset();
        test_sync_timing();
        test_patterns();
        test_scroll();
        test_ena();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
